// File: rtl/f4_pool_reader_pkg.sv
// -----------------------------------------------------------------------------
// f4_pool_reader_pkg
//   Shared constants for the LeNet f4 -> s4 pooling stage: f4 map geometry,
//   channel packing, pooled map size, address widths and the pooling FSM
//   state encoding. Also provides the f4 row/col -> word address helper.
// -----------------------------------------------------------------------------
package f4_pool_reader_pkg;

    localparam int F4_MAP_DIM = 10;               // f4 map is F4_MAP_DIM x F4_MAP_DIM
    localparam int F4_CH      = 16;               // channels per f4 word
    localparam int F4_DW      = 16;               // bits per signed channel sample
    localparam int S4_DIM     = F4_MAP_DIM / 2;   // pooled map side (2x2, stride 2)
    localparam int F4_AW      = 7;                // f4 word address width (0..99)
    localparam int S4_AW      = 5;                // pooled word address width (0..24)

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,   // four f4 reads of one window
        ST_DRAIN = 3'd2,   // last read data folded into the accumulator
        ST_OUT   = 3'd3,   // pooled word offered to the consumer
        ST_DONE  = 3'd4    // one-cycle done pulse
    } pool_state_t;

    // Row-major f4 word address.
    function automatic logic [F4_AW-1:0] f4_addr(input int map_dim, input int row,
                                                 input int col);
        return F4_AW'(row * map_dim + col);
    endfunction

endpackage

// File: rtl/f4_pool_reader_if.sv
// -----------------------------------------------------------------------------
// f4_pool_reader_if
//   Bundles the f4 buffer read port and the s4 pooled-word output stream.
//   master : the pooling reader (drives reads and the output stream)
//   slave  : the f4 buffer / s4 consumer side
//   f4_ren, f4_raddr -> read request; f4_rdata valid the cycle after f4_ren
//   s4_valid/s4_ready handshake carrying s4_wdata at s4_waddr
// -----------------------------------------------------------------------------
interface f4_pool_reader_if
    import f4_pool_reader_pkg::*;
#(
    parameter int WORD_W = F4_CH * F4_DW
);
    logic              f4_ren;
    logic [F4_AW-1:0]  f4_raddr;
    logic [WORD_W-1:0] f4_rdata;
    logic              s4_valid;
    logic              s4_ready;
    logic [WORD_W-1:0] s4_wdata;
    logic [S4_AW-1:0]  s4_waddr;

    modport master (
        output f4_ren, f4_raddr,
        input  f4_rdata,
        output s4_valid,
        input  s4_ready,
        output s4_wdata, s4_waddr
    );

    modport slave (
        input  f4_ren, f4_raddr,
        output f4_rdata,
        input  s4_valid,
        output s4_ready,
        input  s4_wdata, s4_waddr
    );
endinterface

// File: rtl/f4_pool_reader_pool_cmp.sv
// -----------------------------------------------------------------------------
// pool_cmp
//   One channel of the running max. Combinational.
//   first  : sample is the first of its window, take it unconditionally
//   acc    : current running max (signed)
//   sample : new f4 channel sample (signed)
//   y      : updated running max
// -----------------------------------------------------------------------------
module pool_cmp #(
    parameter int DW = 16
) (
    input  logic                 first,
    input  logic signed [DW-1:0] acc,
    input  logic signed [DW-1:0] sample,
    output logic signed [DW-1:0] y
);
    // Strictly greater: on ties the earlier sample is kept.
    assign y = (first || (sample > acc)) ? sample : acc;
endmodule

// File: rtl/f4_pool_reader.sv
// -----------------------------------------------------------------------------
// f4_pool_reader
//   Reads the completed f4 feature map window by window and emits the 2x2
//   stride-2 per-channel signed max as s4 words.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : one-cycle pulse, f4 buffer is complete
//   busy  : pooling in progress
//   done  : one-cycle pulse after the last pooled word is accepted
//   bus   : f4 read port and s4 output stream (master side)
// -----------------------------------------------------------------------------
module f4_pool_reader
    import f4_pool_reader_pkg::*;
#(
    parameter int MAP_DIM = F4_MAP_DIM,
    parameter int CH      = F4_CH,
    parameter int DW      = F4_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    f4_pool_reader_if.master bus
);

    pool_state_t        state;
    logic [2:0]         pr, pc;          // current window
    logic [2:0]         pr_nxt, pc_nxt;  // following window in row-major order
    logic [1:0]         sub;             // read index within window: {dr, dc}
    logic [1:0]         sub_nxt;
    logic               rd_vld;          // f4_rdata carries a sample this cycle
    logic               rd_first;        // ... and it is the first of its window
    logic               last_window;
    logic [CH*DW-1:0]   acc;
    logic [CH*DW-1:0]   acc_next;
    logic [F4_AW-1:0]   raddr_sub_nxt;
    logic [F4_AW-1:0]   raddr_win_nxt;

    // Per-channel compare-and-select on the returning read data.
    for (genvar k = 0; k < CH; k++) begin : g_cmp
        pool_cmp #(.DW(DW)) u_cmp (
            .first  (rd_first),
            .acc    (acc[k*DW +: DW]),
            .sample (bus.f4_rdata[k*DW +: DW]),
            .y      (acc_next[k*DW +: DW])
        );
    end

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        pc_nxt = pc + 3'd1;
        pr_nxt = pr;
        if (pc == 3'(S4_DIM - 1)) begin
            pc_nxt = '0;
            pr_nxt = pr + 3'd1;
        end
    end

    assign last_window   = (pr == 3'(S4_DIM - 1)) && (pc == 3'(S4_DIM - 1));
    assign sub_nxt       = sub + 2'd1;
    assign raddr_sub_nxt = f4_addr(MAP_DIM, 2 * int'(pr) + int'(sub_nxt[1]),
                                   2 * int'(pc) + int'(sub_nxt[0]));
    assign raddr_win_nxt = f4_addr(MAP_DIM, 2 * int'(pr_nxt), 2 * int'(pc_nxt));

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the accumulator is an ordinary register bank, not a RAM,
            // so clearing it on reset costs nothing and keeps s4_wdata defined.
            state        <= ST_IDLE;
            pr           <= '0;
            pc           <= '0;
            sub          <= '0;
            rd_vld       <= 1'b0;
            rd_first     <= 1'b0;
            acc          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.f4_ren   <= 1'b0;
            bus.f4_raddr <= '0;
            bus.s4_valid <= 1'b0;
            bus.s4_wdata <= '0;
            bus.s4_waddr <= '0;
        end else begin
            // Read data returns one cycle after the request.
            rd_vld   <= (state == ST_READ);
            rd_first <= (state == ST_READ) && (sub == 2'd0);
            if (rd_vld) begin
                acc <= acc_next;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_READ;
                        busy         <= 1'b1;
                        pr           <= '0;
                        pc           <= '0;
                        sub          <= '0;
                        bus.f4_ren   <= 1'b1;
                        bus.f4_raddr <= f4_addr(MAP_DIM, 0, 0);
                    end
                end

                ST_READ: begin
                    if (sub == 2'd3) begin
                        state        <= ST_DRAIN;
                        sub          <= '0;
                        bus.f4_ren   <= 1'b0;
                        bus.f4_raddr <= '0;
                    end else begin
                        sub          <= sub_nxt;
                        bus.f4_raddr <= raddr_sub_nxt;
                    end
                end

                ST_DRAIN: begin
                    // acc_next already includes the fourth sample here.
                    state        <= ST_OUT;
                    bus.s4_valid <= 1'b1;
                    bus.s4_wdata <= acc_next;
                    bus.s4_waddr <= S4_AW'(int'(pr) * S4_DIM + int'(pc));
                end

                ST_OUT: begin
                    if (bus.s4_ready) begin
                        bus.s4_valid <= 1'b0;
                        if (last_window) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state        <= ST_READ;
                            pr           <= pr_nxt;
                            pc           <= pc_nxt;
                            bus.f4_ren   <= 1'b1;
                            bus.f4_raddr <= raddr_win_nxt;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    pr    <= '0;
                    pc    <= '0;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_f4_pool_reader.sv
// -----------------------------------------------------------------------------
// tb_f4_pool_reader
//   Self-checking bench for f4_pool_reader. A behavioural f4 memory answers
//   reads; expected pooled words and read order are computed from the pooling
//   rule directly over the memory contents.
// -----------------------------------------------------------------------------
module tb_f4_pool_reader;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;

    f4_pool_reader_if bus_if ();

    f4_pool_reader dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- f4 memory model ----------------
    logic [255:0] mem [100];
    initial bus_if.f4_rdata = '0;
    always @(posedge clk) begin
        if (bus_if.f4_ren) bus_if.f4_rdata <= mem[bus_if.f4_raddr];
    end

    // ---------------- consumer ready driver ----------------
    int rmode = 0;   // 0: always ready, 1: hold 3 cycles at waddr 7, 2: random
    int bp_cnt = 0;
    initial bus_if.s4_ready = 1'b1;
    always begin
        @(posedge clk);
        #1;
        case (rmode)
            1: begin
                if (bus_if.s4_valid && bus_if.s4_waddr == 5'd7 && bp_cnt < 3) begin
                    bus_if.s4_ready = 1'b0;
                    bp_cnt++;
                end else begin
                    bus_if.s4_ready = 1'b1;
                end
            end
            2:       bus_if.s4_ready = 1'($urandom_range(0, 1));
            default: bus_if.s4_ready = 1'b1;
        endcase
    end

    // ---------------- monitor ----------------
    int           rd_q[$];
    int           hs_addr[$];
    logic [255:0] hs_data[$];
    int           done_cnt;
    int           first_ren_cyc, first_vld_cyc, done_cyc;
    bit           hold = 1'b0;
    logic [4:0]   hold_addr;
    logic [255:0] hold_data;

    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (bus_if.f4_ren) begin
                rd_q.push_back(int'(bus_if.f4_raddr));
                if (first_ren_cyc < 0) first_ren_cyc = cyc;
            end
            if (bus_if.s4_valid) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                check("ren_during_out", bus_if.f4_ren, 0);
            end
            if (hold) begin
                check("hold_valid", bus_if.s4_valid, 1);
                check("hold_waddr", bus_if.s4_waddr, hold_addr);
                check("hold_wdata", bus_if.s4_wdata, hold_data);
            end
            if (bus_if.s4_valid && bus_if.s4_ready) begin
                hs_addr.push_back(int'(bus_if.s4_waddr));
                hs_data.push_back(bus_if.s4_wdata);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            hold      = bus_if.s4_valid && !bus_if.s4_ready;
            hold_addr = bus_if.s4_waddr;
            hold_data = bus_if.s4_wdata;
        end
    end

    // ---------------- reference model ----------------
    logic [255:0] exp_pool [25];
    int           exp_reads[$];

    task automatic build_model();
        exp_reads.delete();
        for (int pr = 0; pr < 5; pr++) begin
            for (int pc = 0; pc < 5; pc++) begin
                for (int d = 0; d < 4; d++)
                    exp_reads.push_back((2 * pr + d / 2) * 10 + 2 * pc + d % 2);
                for (int ch = 0; ch < 16; ch++) begin
                    logic signed [15:0] m, v;
                    m = mem[(2 * pr) * 10 + 2 * pc][16 * ch +: 16];
                    for (int d = 1; d < 4; d++) begin
                        v = mem[(2 * pr + d / 2) * 10 + 2 * pc + d % 2][16 * ch +: 16];
                        if (v > m) m = v;
                    end
                    exp_pool[pr * 5 + pc][16 * ch +: 16] = m;
                end
            end
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 100; a++)
            for (int j = 0; j < 8; j++)
                mem[a][32 * j +: 32] = $urandom;
    endtask

    task automatic clear_obs();
        rd_q.delete();
        hs_addr.delete();
        hs_data.delete();
        done_cnt      = 0;
        first_ren_cyc = -1;
        first_vld_cyc = -1;
        done_cyc      = -1;
        bp_cnt        = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ren"},   bus_if.f4_ren,   0);
        check({tag, "_raddr"}, bus_if.f4_raddr, 0);
        check({tag, "_valid"}, bus_if.s4_valid, 0);
        check({tag, "_waddr"}, bus_if.s4_waddr, 0);
        check({tag, "_wdata"}, bus_if.s4_wdata, 0);
        check({tag, "_busy"},  busy,            0);
        check({tag, "_done"},  done,            0);
    endtask

    // One full pooling pass; optional extra start pulse at c0+extra_at.
    task automatic run_frame(input int mode, input bit timed, input int extra_at);
        int c0;
        int n;
        build_model();
        clear_obs();
        rmode = mode;
        @(negedge clk);
        start = 1'b1;
        c0    = cyc;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            start = (extra_at > 0) && (cyc == c0 + extra_at);
            n++;
        end
        start = 1'b0;
        check("done_seen", done_cnt != 0, 1);
        repeat (8) @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check("busy_after", busy, 0);
        check("hs_count", hs_addr.size(), 25);
        for (int i = 0; i < 25 && i < hs_addr.size(); i++) begin
            check($sformatf("waddr[%0d]", i), hs_addr[i], i);
            check($sformatf("wdata[%0d]", i), hs_data[i], exp_pool[i]);
        end
        check("read_count", rd_q.size(), 100);
        for (int i = 0; i < 100 && i < rd_q.size(); i++)
            check($sformatf("raddr[%0d]", i), rd_q[i], exp_reads[i]);
        if (timed) begin
            check("first_ren_cycle", first_ren_cyc - c0, 1);
            check("first_valid_cycle", first_vld_cyc - c0, 6);
            check("done_cycle", done_cyc - c0, 151);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [255:0] w;
        logic [15:0]  v;
        int           n;

        rst   = 1'b1;
        start = 1'b0;
        for (int a = 0; a < 100; a++) mem[a] = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // Ramp: every channel of word a equals a.
        for (int a = 0; a < 100; a++) begin
            v      = 16'(a);
            mem[a] = {16{v}};
        end
        run_frame(0, 1'b1, 0);
        w = (hs_data.size() > 0)  ? hs_data[0]  : '0;
        check("ramp_w0",  w, {16{16'd11}});
        w = (hs_data.size() > 4)  ? hs_data[4]  : '0;
        check("ramp_w4",  w, {16{16'd19}});
        w = (hs_data.size() > 24) ? hs_data[24] : '0;
        check("ramp_w24", w, {16{16'd99}});

        // Signed compare, first sample loaded directly.
        fill_random();
        mem[0][15:0]  = 16'hFFFB;
        mem[1][15:0]  = 16'h8000;
        mem[10][15:0] = 16'hFFFB;
        mem[11][15:0] = 16'hFFF0;
        run_frame(0, 1'b0, 0);
        w = (hs_data.size() > 0) ? hs_data[0] : '0;
        check("signed_neg", w[15:0], 16'hFFFB);
        mem[0][15:0]  = 16'h7FFF;
        mem[1][15:0]  = 16'h7FFF;
        mem[10][15:0] = 16'h7FFF;
        mem[11][15:0] = 16'h7FFF;
        run_frame(0, 1'b0, 0);
        w = (hs_data.size() > 0) ? hs_data[0] : '0;
        check("signed_max", w[15:0], 16'h7FFF);

        // Backpressure at waddr 7, then random backpressure.
        fill_random();
        run_frame(1, 1'b0, 0);
        check("bp_low_cycles", bp_cnt, 3);
        fill_random();
        run_frame(2, 1'b0, 0);

        // Reset during READ of window 12 (first read address 44), with a
        // start in the same cycle that must be discarded.
        fill_random();
        clear_obs();
        rmode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(bus_if.f4_ren && bus_if.f4_raddr == 7'd44) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reached_win12", n < 500, 1);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_all_zero("midrun_reset");
        @(negedge clk);
        check("start_with_rst_busy", busy, 0);
        check("start_with_rst_ren", bus_if.f4_ren, 0);
        run_frame(0, 1'b1, 0);

        // Extra start while busy in cycle 40.
        fill_random();
        run_frame(0, 1'b1, 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/f4_pool_reader.md
F4_POOL_READER -- requirements
Module: f4_pool_reader

Interface
REQ-001 Parameter MAP_DIM, 10, side length of the square f4 feature map (conv2 output).
REQ-002 Parameter CH, 16, feature channels per f4 word.
REQ-003 Parameter DW, 16, bits per channel sample, signed two's complement.
REQ-004 Port clk, input, 1, sole clock; all logic rising-edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port start, input, 1, one-cycle pulse: f4 buffer fully written, begin pooling.
REQ-007 Port f4_ren, output, 1, f4 buffer read enable.
REQ-008 Port f4_raddr, output, 7, f4 word address = row*MAP_DIM+col, range 0..99.
REQ-009 Port f4_rdata, input, CH*DW (256), f4 word; channel k in bits [16k+15:16k]; valid the cycle after f4_ren.
REQ-010 Port s4_valid, output, 1, pooled word available.
REQ-011 Port s4_ready, input, 1, consumer accepts the word when s4_valid and s4_ready are both high.
REQ-012 Port s4_wdata, output, 256, pooled word, same channel packing as f4_rdata.
REQ-013 Port s4_waddr, output, 5, pooled address = pr*5+pc, range 0..24.
REQ-014 Port busy, output, 1, high from the cycle after accepted start until done.
REQ-015 Port done, output, 1, one-cycle pulse after the last pooled word is accepted.

Function
REQ-016 2x2 max pooling, stride 2: output (pr,pc) = per-channel signed max of f4 (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1).
REQ-017 Window order row-major, pr outer, pc inner; the four reads within a window are issued in the order listed in REQ-016.
REQ-018 FSM states: IDLE, READ (4 cycles, f4_ren high), DRAIN (1 cycle, last sample folded in), OUT (s4_valid high), DONE (1 cycle, done high) -> IDLE.
REQ-019 Transitions: IDLE->READ on start; READ->DRAIN after the 4th read; DRAIN->OUT; OUT->READ on handshake if windows remain; OUT->DONE on handshake of window 24.
REQ-020 Timing: start high in cycle 0 gives f4_ren in cycles 1-4 and s4_valid in cycle 6; with s4_ready held high, one window every 6 cycles, last handshake in cycle 150, done in cycle 151.
REQ-021 First sample of each window is loaded directly into the accumulator (no compare against 0); later samples replace it only if strictly greater (signed).
REQ-022 s4_wdata and s4_waddr are registered and stay stable while s4_valid && !s4_ready; no f4 reads are issued in OUT.
REQ-023 start is ignored while busy; s4_ready is ignored outside OUT.
REQ-024 f4_raddr is 0 and f4_ren low whenever the FSM is not in READ.
REQ-025 Arithmetic is pure comparison; no saturation, rounding or width change.

Reset
REQ-026 rst high at any clock edge, including mid-window or in OUT, forces IDLE and clears the window counters and accumulator; s4_valid, f4_ren, busy and done are 0, and f4_raddr, s4_waddr and s4_wdata are 0, in the following cycle.
REQ-027 A start sampled in the same cycle as rst is discarded.

Structure
REQ-028 MAP_DIM, CH, DW, pooled dimension (5) and the FSM state encoding belong in the shared lenet package.
REQ-029 Per-channel signed compare-and-select is one sub-module, pool_cmp, instantiated CH times in a generate loop.
REQ-030 Estimated implementation size: 150-250 lines of RTL.

Verification
REQ-031 Ramp: every channel of f4 word a = a, s4_ready=1 -> s4_waddr 0 gives 11, waddr 4 gives 19, waddr 24 gives 99 on all channels; done in cycle 151.
REQ-032 Signed: window 0 samples channel 0 = 0xFFFB, 0x8000, 0xFFFB, 0xFFF0 -> channel 0 of waddr 0 = 0xFFFB; all four equal 0x7FFF -> 0x7FFF.
REQ-033 Backpressure: s4_ready low for 3 cycles at waddr 7 -> s4_wdata/s4_waddr stable, f4_ren low, no duplicate or skipped address, 25 handshakes total.
REQ-034 Reset mid-run: rst asserted during READ of window 12 -> next cycle all outputs 0; a new start produces windows 0..24 from scratch.
REQ-035 Start while busy: extra start pulse in cycle 40 -> ignored, exactly one done pulse, 25 outputs.
